// File: rtl/dac_pkg.sv
// Shared definitions for the DAC arbiter and its helpers.
//   dac_state_e       : arbiter FSM state encoding
//   DAC_DATA_W        : default DAC sample width
//   DAC_BUSY_TIMEOUT  : default cycles allowed for the driver to raise busy
//   DAC_TO_W          : default timeout counter width
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    XFER      = 2'd2,
    DONE      = 2'd3
  } dac_state_e;

  localparam int unsigned DAC_DATA_W       = 8;
  localparam int unsigned DAC_BUSY_TIMEOUT = 16;
  localparam int unsigned DAC_TO_W         = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req   : request vector, bit i from requester i
//   last  : index of the requester served most recently
//   grant : index of the chosen requester (only meaningful when valid)
//   valid : at least one request is pending
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Contention: hand the word to whoever did not go last.
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/dac_arbiter.sv
// Shares one DAC driver between two sample sources.
// Each grant launches exactly one driver transfer: the chosen sample is
// registered onto dac_data, dac_begin strobes for one cycle, and the owner
// gets a one-cycle ack once the driver has gone busy and then idle again.
// A driver that never raises busy within BUSY_TIMEOUT cycles aborts the
// transfer (no ack) and sets the sticky err flag.
//   clk, rst      : clock, asynchronous active-high reset
//   req0/data0    : source 0 request (held until ack0) and sample
//   req1/data1    : source 1 request (held until ack1) and sample
//   ack0/ack1     : one-cycle completion pulses, never both high
//   dac_begin     : one-cycle start strobe to the driver
//   dac_data      : sample for the driver, held for the whole transfer
//   dac_busy      : driver shifting/converting
//   err, err_clr  : sticky timeout flag and its synchronous clear
// BUSY_TIMEOUT must be >= 2 and representable in TO_W bits.
module dac_arbiter
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W       = DAC_DATA_W,
  parameter int unsigned BUSY_TIMEOUT = DAC_BUSY_TIMEOUT,
  parameter int unsigned TO_W         = DAC_TO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              dac_begin,
  output logic [DATA_W-1:0] dac_data,
  input  logic              dac_busy,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(BUSY_TIMEOUT - 1);

  dac_state_e      state;
  logic            owner;
  logic            last;
  logic [TO_W-1:0] cnt;

  logic            pick;
  logic            pick_valid;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .last  (last),
    .grant (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      // Pretend source 1 went last so source 0 wins the first contention.
      last      <= 1'b1;
      cnt       <= '0;
      dac_begin <= 1'b0;
      dac_data  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
    end else begin
      dac_begin <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      // A timeout in the same cycle overrides this below, so set wins.
      if (err_clr) begin
        err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick;
            dac_data  <= pick ? data1 : data0;
            dac_begin <= 1'b1;
            cnt       <= '0;
            state     <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (dac_busy) begin
            state <= XFER;
          end else if (cnt == CntLast) begin
            // Abort without ack; the owner keeps its request and the
            // round-robin serves the other side first if it is waiting.
            err   <= 1'b1;
            last  <= owner;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          if (!dac_busy) begin
            ack0  <= ~owner;
            ack1  <= owner;
            last  <= owner;
            state <= DONE;
          end
        end

        DONE: begin
          // Gives the owner the ack cycle to drop its request.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_arbiter.sv
module tb_dac_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic       dac_begin;
  logic [7:0] dac_data;
  logic       dac_busy;
  logic       err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  // Behavioural driver model controls.
  logic drv_en  = 1'b1;
  int   drv_len = 5;

  typedef struct {
    logic       src;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         len;
    logic       src;
    logic [7:0] data;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  logic mon_active = 1'b0;

  dac_arbiter #(
    .DATA_W       (8),
    .BUSY_TIMEOUT (16),
    .TO_W         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .dac_begin (dac_begin),
    .dac_data  (dac_data),
    .dac_busy  (dac_busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Driver: goes busy at the first falling edge after the strobe, stays busy
  // for drv_len rising edges.
  initial begin
    dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_begin && drv_en && !rst) begin
        dac_busy = 1'b1;
        repeat (drv_len) @(negedge clk);
        dac_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Scoreboard: every strobe pops an expectation, every ack is matched to it.
  task automatic monitor();
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (dac_begin) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_begin", "dac_begin with nothing expected");
        end else begin
          cur = exp_q.pop_front();
          check("begin_data", dac_data, cur.data);
          mon_active = 1'b1;
        end
      end else if (mon_active) begin
        check("data_held", dac_data, cur.data);
      end
      if (ack0 || ack1) begin
        if (!mon_active) begin
          fail("spurious_ack", "ack with no transfer in flight");
        end else begin
          check("ack_owner", {ack1, ack0}, cur.src ? 2'b10 : 2'b01);
        end
        mon_active = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_begin(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dac_begin && n < 100);
    if (!dac_begin) fail(name, "timed out waiting for dac_begin");
  endtask

  task automatic wait_ack(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack0 || ack1) && n < 200);
    if (!(ack0 || ack1)) fail(name, "timed out waiting for ack");
  endtask

  task automatic do_vec(input vec_t v);
    int n;
    int m;
    drv_len = v.len;
    req0    = v.r0;
    req1    = v.r1;
    data0   = v.d0;
    data1   = v.d1;
    exp_q.push_back('{src: v.src, data: v.data});
    wait_begin("vec_begin", n);
    check("begin_latency", n, 1);
    tick();
    check("begin_one_cycle", dac_begin, 0);
    wait_ack("vec_ack", m);
    check("ack_latency", m + 1, v.len + 1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("ack_one_cycle", {ack1, ack0}, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int k;
    logic ack_seen;

    rst     = 1'b1;
    req0    = 1'b0;
    req1    = 1'b0;
    data0   = 8'd0;
    data1   = 8'd0;
    err_clr = 1'b0;

    // Expected grant follows the round-robin with last=1 after reset.
    vecs[0] = '{r0: 1, r1: 0, d0: 8'd177, d1: 8'd0,   len: 5, src: 0, data: 8'd177};
    vecs[1] = '{r0: 1, r1: 1, d0: 8'd10,  d1: 8'd246, len: 3, src: 1, data: 8'd246};
    vecs[2] = '{r0: 1, r1: 1, d0: 8'd10,  d1: 8'd246, len: 2, src: 0, data: 8'd10};
    vecs[3] = '{r0: 0, r1: 1, d0: 8'd0,   d1: 8'd55,  len: 1, src: 1, data: 8'd55};
    vecs[4] = '{r0: 0, r1: 1, d0: 8'd0,   d1: 8'd66,  len: 4, src: 1, data: 8'd66};
    vecs[5] = '{r0: 1, r1: 1, d0: 8'd1,   d1: 8'd2,   len: 2, src: 0, data: 8'd1};
    vecs[6] = '{r0: 1, r1: 0, d0: 8'd255, d1: 8'd9,   len: 3, src: 0, data: 8'd255};
    vecs[7] = '{r0: 1, r1: 1, d0: 8'd3,   d1: 8'd4,   len: 6, src: 1, data: 8'd4};

    repeat (3) tick();
    check("rst_begin", dac_begin, 0);
    check("rst_data", dac_data, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) do_vec(vecs[i]);

    // Continuous contention: last=1 now, so grants go 0,1,0,1.
    drv_len = 3;
    req0    = 1'b1;
    req1    = 1'b1;
    data0   = 8'd10;
    data1   = 8'd246;
    for (int i = 0; i < 4; i++) exp_q.push_back('{src: i[0], data: i[0] ? 8'd246 : 8'd10});
    for (int i = 0; i < 4; i++) begin
      wait_ack("alt_ack", n);
      check("alt_period", n, (i == 0) ? 5 : 6);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check("alt_no_extra", dac_begin, 0);
    check("alt_queue_empty", exp_q.size(), 0);

    // Sample change mid-transfer must not reach dac_data.
    drv_len = 6;
    req0    = 1'b1;
    data0   = 8'd128;
    exp_q.push_back('{src: 0, data: 8'd128});
    exp_q.push_back('{src: 0, data: 8'd0});
    wait_begin("hold_begin", n);
    tick();
    tick();
    data0 = 8'd0;
    wait_ack("hold_ack", n);
    check("hold_data_at_ack", dac_data, 128);
    wait_begin("hold_begin2", n);
    check("next_data", dac_data, 0);
    wait_ack("hold_ack2", n);
    req0 = 1'b0;
    tick();

    // Driver that never goes busy.
    drv_en = 1'b0;
    req0   = 1'b1;
    data0  = 8'd7;
    exp_q.push_back('{src: 0, data: 8'd7});
    exp_q.push_back('{src: 0, data: 8'd7});
    wait_begin("to_begin", n);
    k        = 0;
    ack_seen = 1'b0;
    do begin
      tick();
      k++;
      if (ack0 || ack1) ack_seen = 1'b1;
    end while (!err && k < 40);
    check("err_delay", k, 16);
    check("to_no_ack", ack_seen, 0);
    tick();
    check("to_regrant", dac_begin, 1);
    check("to_err_sticky", err, 1);
    req0    = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", err, 0);
    repeat (14) tick();
    check("err_before_to2", err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    check("to2_no_ack", {ack1, ack0}, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr2", err, 0);
    drv_en = 1'b1;
    tick();

    // Reset while the driver is shifting.
    drv_len = 8;
    req0    = 1'b1;
    data0   = 8'd99;
    exp_q.push_back('{src: 0, data: 8'd99});
    wait_begin("rst_xfer_begin", n);
    repeat (3) tick();
    rst  = 1'b1;
    req0 = 1'b0;
    tick();
    check("midrst_data", dac_data, 0);
    check("midrst_begin", dac_begin, 0);
    check("midrst_ack", {ack1, ack0}, 0);
    tick();
    rst = 1'b0;
    k   = 0;
    while (dac_busy && k < 50) begin
      tick();
      k++;
    end
    if (dac_busy) fail("driver_idle", "driver model never went idle");
    tick();
    check("post_rst_no_ack", {ack1, ack0}, 0);
    req1  = 1'b1;
    data1 = 8'd200;
    exp_q.push_back('{src: 1, data: 8'd200});
    wait_begin("post_rst_begin", n);
    check("post_rst_latency", n, 1);
    wait_ack("post_rst_ack", n);
    req1 = 1'b0;
    tick();
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
